alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Execute-stage ALU that consumes the 3-bit `ALUControl` code produced by the ALU decoder, together with the two source operands, and returns a registered result. Single-cycle operations (ADD, SUB, AND, OR, SLT, SGT, SLL) complete one cycle after acceptance. MUL runs on an iterative shift-add multiplier over several cycles. A valid/ready handshake on both sides lets the hazard unit stall the pipeline while a multiply is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width in bits; must be a power of two, ≥ 8.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operation and operands presented
- `in_ready`  out  1  block can accept an operation this cycle
- `ALUControl`  in  3  operation code; encodings are the `*_FUNCT3` macros in constants.v
- `SrcA`  in  WIDTH  operand A
- `SrcB`  in  WIDTH  operand B
- `out_valid`  out  1  `ALUResult` and `Zero` are valid
- `out_ready`  in  1  consumer accepts the result
- `ALUResult`  out  WIDTH  registered result
- `Zero`  out  1  registered flag; `ALUResult == 0`
- `busy`  out  1  high in MUL state (stall request)

## Operation
- States are IDLE, MUL and DONE. Reset forces IDLE, `out_valid`=0, `ALUResult`=0, `Zero`=0, `busy`=0 and clears the internal registers.
- `in_ready` = (IDLE) or (DONE and `out_ready`).
- Accept occurs when `in_valid` and `in_ready` are both high. Operands and opcode are sampled only at accept; later input changes are ignored.
- Non-MUL ops on accept:
  - Compute the result, register it with `Zero`, and go to DONE.
  - `ADD_FUNCT3`: A+B mod 2^WIDTH.
  - `SUB_FUNCT3`: A−B mod 2^WIDTH.
  - `AND_FUNCT3`: A&B.
  - `OR_FUNCT3`: A|B.
  - `SLT_FUNCT3`: 1 if signed A<B, else 0.
  - `SGT_FUNCT3`: 1 if signed A>B, else 0.
  - `SLL_FUNCT3`: A << B[log2(WIDTH)−1:0].
- `MUL_FUNCT3` on accept:
  - Load acc=0, mcand=A, mplier=B, count=0, then go to MUL.
  - Each MUL cycle: if mplier[0], acc += mcand (mod 2^WIDTH); mcand <<= 1; mplier >>= 1; count++.
  - After the step with count reaching WIDTH, go to DONE with `ALUResult` = acc (low WIDTH bits of the product, unsigned and signed identical).
- DONE: `out_valid`=1. `ALUResult` and `Zero` are held stable while `out_ready`=0.
  - `out_ready`=1 without a new accept → IDLE, `out_valid`=0.
  - `out_ready`=1 with a simultaneous accept → the result is handed off and the new op is processed as from IDLE (back-to-back).
- Boundary conditions:
  - `in_valid` during MUL is ignored and no accept occurs; upstream holds its inputs.
  - `reset` during MUL abandons the op; no `out_valid` is produced.
  - SLL shift amount 0 returns A; bits of B above log2(WIDTH) are ignored.

## Timing
- Cycle 0 is the accept cycle.
- Non-MUL op: `out_valid` in cycle 1.
- MUL (full): `busy` in cycles 1..WIDTH; `out_valid` in cycle WIDTH+1.
- Throughput: one non-MUL op per cycle with `out_ready` held high.
- `ALUResult` and `Zero` change only on an accept-driven or MUL-completion edge, or on reset.

## Configuration
- `ALU_MUL_EARLY_EXIT_EN` defined:
  - The MUL state also exits to DONE after any step that leaves mplier == 0. At least one MUL cycle is always taken.
  - Latency: `out_valid` in cycle k+1, where k = max(1, index of the highest set bit of B + 1).
- Undefined: every MUL takes exactly WIDTH MUL cycles.
- Results are identical in both builds.

## Test plan
- Reset mid-multiply: accept MUL A=7, B=9; assert `reset` in cycle 5 → IDLE, `out_valid` stays 0, `ALUResult`=0, `in_ready`=1 the cycle after release.
- Back-to-back single-cycle ops with `out_ready`=1:
  - ADD 0xFFFFFFFF+1 → 0, `Zero`=1, cycle 1.
  - SUB 5−7 → 0xFFFFFFFE.
  - SLT 0x80000000 vs 1 → 1.
  - SGT same operands → 0.
  - SLL 1 << 0x21 → 2.
- Full multiply (macro off): MUL 0xFFFFFFFF×3 → 0xFFFFFFFD, `busy` in cycles 1..32, `out_valid` in cycle 33; `in_valid` pulsed during `busy` is not accepted.
- Output backpressure: AND 0xF0F0×0xFF00 → 0xF000 with `out_ready`=0 for 4 cycles → result held and `in_ready`=0; `out_ready`=1 with a new OR 1|2 → 3 valid on the next cycle.
- Early exit (macro on): MUL 6×3 → 18, `out_valid` in cycle 3; MUL 5×0 → 0, `Zero`=1, `out_valid` in cycle 2.

Source files
------------

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute-stage ALU with valid/ready handshake and iterative shift-add MUL
// Optional build macro: ALU_MUL_EARLY_EXIT_EN (MUL leaves as soon as the multiplier is exhausted).

`ifndef ADD_FUNCT3
`define ADD_FUNCT3 3'b000
`endif
`ifndef SUB_FUNCT3
`define SUB_FUNCT3 3'b001
`endif
`ifndef AND_FUNCT3
`define AND_FUNCT3 3'b010
`endif
`ifndef OR_FUNCT3
`define OR_FUNCT3  3'b011
`endif
`ifndef SLT_FUNCT3
`define SLT_FUNCT3 3'b100
`endif
`ifndef SGT_FUNCT3
`define SGT_FUNCT3 3'b101
`endif
`ifndef SLL_FUNCT3
`define SLL_FUNCT3 3'b110
`endif
`ifndef MUL_FUNCT3
`define MUL_FUNCT3 3'b111
`endif

module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, result_q;
    logic [CW-1:0]    cnt_q;
    logic             zero_q, out_valid_q, busy_q;

    logic [WIDTH-1:0] op_res_d, acc_d;
    logic [CW-1:0]    cnt_d;
    logic             mul_last, accept;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign busy      = busy_q;

    always_comb begin
        op_res_d = '0;
        case (ALUControl)
            `ADD_FUNCT3: op_res_d = SrcA + SrcB;
            `SUB_FUNCT3: op_res_d = SrcA - SrcB;
            `AND_FUNCT3: op_res_d = SrcA & SrcB;
            `OR_FUNCT3:  op_res_d = SrcA | SrcB;
            `SLT_FUNCT3: op_res_d = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            `SGT_FUNCT3: op_res_d = {{(WIDTH-1){1'b0}}, ($signed(SrcA) > $signed(SrcB))};
            `SLL_FUNCT3: op_res_d = SrcA << SrcB[SHW-1:0];
            default:     op_res_d = '0;
        endcase
    end

    // One shift-add step per MUL cycle; mul_last marks the step that finishes the product.
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        cnt_d = cnt_q + 1'b1;
`ifdef ALU_MUL_EARLY_EXIT_EN
        mul_last = (cnt_d == CNT_LAST) || ((mplier_q >> 1) == '0);
`else
        mul_last = (cnt_d == CNT_LAST);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_d;
                    if (mul_last) begin
                        state_q     <= S_DONE;
                        result_q    <= acc_d;
                        zero_q      <= (acc_d == '0);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    // Hand-off first; a simultaneous accept below overrides it (back-to-back).
                    if ((state_q == S_DONE) && out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        if (ALUControl == `MUL_FUNCT3) begin
                            state_q     <= S_MUL;
                            acc_q       <= '0;
                            mcand_q     <= SrcA;
                            mplier_q    <= SrcB;
                            cnt_q       <= '0;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= S_DONE;
                            result_q    <= op_res_d;
                            zero_q      <= (op_res_d == '0);
                            out_valid_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle with a result scoreboard

`ifndef ADD_FUNCT3
`define ADD_FUNCT3 3'b000
`endif
`ifndef SUB_FUNCT3
`define SUB_FUNCT3 3'b001
`endif
`ifndef AND_FUNCT3
`define AND_FUNCT3 3'b010
`endif
`ifndef OR_FUNCT3
`define OR_FUNCT3  3'b011
`endif
`ifndef SLT_FUNCT3
`define SLT_FUNCT3 3'b100
`endif
`ifndef SGT_FUNCT3
`define SGT_FUNCT3 3'b101
`endif
`ifndef SLL_FUNCT3
`define SLL_FUNCT3 3'b110
`endif
`ifndef MUL_FUNCT3
`define MUL_FUNCT3 3'b111
`endif

module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUControl;
    logic [W-1:0] SrcA, SrcB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;
    logic         Zero;
    logic         busy;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
    endtask

    task automatic push(input string tag, input logic [W-1:0] res);
        exp_t e;
        e.res  = res;
        e.zero = (res == '0);
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        chk("sb_nonempty", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_valid"}, W'(out_valid), W'(1));
            chk({e.tag, "_result"}, ALUResult, e.res);
            chk({e.tag, "_zero"}, W'(Zero), W'(e.zero));
        end
    endtask

    // Number of MUL-state cycles the multiplier should spend for operand B.
    function automatic int mul_cycles(input logic [W-1:0] b);
        int k;
        k = W;
`ifdef ALU_MUL_EARLY_EXIT_EN
        k = 1;
        for (int i = 0; i < W; i++)
            if (b[i]) k = i + 1;
`endif
        return k;
    endfunction

    task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res);
        int k;
        k = mul_cycles(b);
        drive(`MUL_FUNCT3, a, b);
        push(tag, res);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= k; c++) begin
            chk({tag, "_busy"}, W'(busy), W'(1));
            chk({tag, "_nv"}, W'(out_valid), W'(0));
            chk({tag, "_inrdy"}, W'(in_ready), W'(0));
            if (c == 1 && k >= 2) drive(`ADD_FUNCT3, 32'h1, 32'h1);
            if (c == 2) in_valid = 1'b0;
            tick();
        end
        chk({tag, "_busy_end"}, W'(busy), W'(0));
        check_pop();
        tick();
        chk({tag, "_idle"}, W'(out_valid), W'(0));
        tick();
        chk({tag, "_no_stray"}, W'(out_valid), W'(0));
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        ALUControl = '0;
        SrcA       = '0;
        SrcB       = '0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_result", ALUResult, '0);
        chk("rst_zero", W'(Zero), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        reset = 1'b0;
        tick();
        chk("rst_in_ready", W'(in_ready), W'(1));

        // Reset in the middle of a multiply abandons it.
        drive(`MUL_FUNCT3, 32'd7, 32'd9);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            chk("rmul_busy", W'(busy), W'(1));
            tick();
        end
        reset = 1'b1;
        #1;
        chk("rmul_nv", W'(out_valid), W'(0));
        chk("rmul_result", ALUResult, '0);
        chk("rmul_busy0", W'(busy), W'(0));
        tick();
        reset = 1'b0;
        tick();
        chk("rmul_in_ready", W'(in_ready), W'(1));
        chk("rmul_nv2", W'(out_valid), W'(0));
        chk("rmul_result2", ALUResult, '0);

        // Back-to-back single-cycle ops, one result per cycle.
        drive(`ADD_FUNCT3, 32'hFFFF_FFFF, 32'h1);          push("add_wrap", 32'h0);
        tick(); check_pop();
        drive(`SUB_FUNCT3, 32'd5, 32'd7);                 push("sub_neg", 32'hFFFF_FFFE);
        tick(); check_pop();
        drive(`SLT_FUNCT3, 32'h8000_0000, 32'h1);         push("slt", 32'h1);
        tick(); check_pop();
        drive(`SGT_FUNCT3, 32'h8000_0000, 32'h1);         push("sgt", 32'h0);
        tick(); check_pop();
        drive(`SLL_FUNCT3, 32'h1, 32'h21);                push("sll_wrapamt", 32'h2);
        tick(); check_pop();
        drive(`SLL_FUNCT3, 32'h0000_ABCD, 32'h40);        push("sll_zero", 32'h0000_ABCD);
        tick(); check_pop();
        drive(`OR_FUNCT3, 32'h1200_0000, 32'h0000_0034);  push("or", 32'h1200_0034);
        tick(); check_pop();
        drive(`SGT_FUNCT3, 32'h1, 32'hFFFF_FFFF);         push("sgt_true", 32'h1);
        tick(); check_pop();
        in_valid = 1'b0;
        tick();
        chk("b2b_idle", W'(out_valid), W'(0));

        // Multiplies; latency follows the build (full or early exit).
        do_mul("mul_full", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        do_mul("mul_6x3", 32'd6, 32'd3, 32'd18);
        do_mul("mul_5x0", 32'd5, 32'd0, 32'd0);
        do_mul("mul_signed", 32'hFFFF_FFFE, 32'd12345, 32'hFFFF_9F8E);

        // Output backpressure with upstream waiting, then hand-off plus accept.
        out_ready = 1'b0;
        drive(`AND_FUNCT3, 32'h0000_F0F0, 32'h0000_FF00);
        push("and_bp", 32'h0000_F000);
        tick();
        drive(`OR_FUNCT3, 32'h1, 32'h2);
        for (int c = 0; c < 4; c++) begin
            chk("bp_valid", W'(out_valid), W'(1));
            chk("bp_hold", ALUResult, 32'h0000_F000);
            chk("bp_in_ready", W'(in_ready), W'(0));
            tick();
        end
        check_pop();
        out_ready = 1'b1;
        push("or_after_bp", 32'h3);
        tick();
        in_valid = 1'b0;
        check_pop();
        tick();
        chk("bp_idle", W'(out_valid), W'(0));
        chk("sb_drained", W'(sb.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
